hazard_unit_param: RTL

Parametrised hazard and forwarding controller for the pipelined ARM core (F/D/E/M/W). It performs its register-address comparisons internally for any number of E-stage source operands, and detects load-use hazards across all D-stage sources. It also tracks in-flight PC writes through its own E/M/W shadow pipeline and freezes the pipe during data-memory stalls. Saturating counters record load-use and memory stall cycles for performance tuning.

---
 rtl/hazard_unit_param_if.sv | 55 +++++
 rtl/hazard_unit_param.sv | 138 +++++++++++++
 2 files changed

// File: rtl/hazard_unit_param_if.sv
// Hazard unit bundle: every pipeline-facing signal of the hazard and forwarding
// controller.
//   master : the pipeline datapath. It drives the register addresses, valids and
//            control hints, and it receives the stall, flush and forward controls.
//   slave  : the hazard unit itself.
// Source i of RA_D/RA_E is at bits [i*RAW +: RAW].
// The forward select for source i is at ForwardE[2*i +: 2].
interface hazard_unit_param_if #(
    parameter int NSRC = 2,
    parameter int RAW  = 4,
    parameter int CNTW = 16
);
    logic [NSRC*RAW-1:0] RA_D;
    logic [NSRC-1:0]     RAValidD;
    logic [NSRC*RAW-1:0] RA_E;
    logic [NSRC-1:0]     RAValidE;
    logic [RAW-1:0]      WA_E;
    logic [RAW-1:0]      WA_M;
    logic [RAW-1:0]      WA_W;
    logic                MemtoRegE;
    logic                RegWriteM;
    logic                RegWriteW;
    logic                BranchTakenE;
    logic                PCSrcD;
    logic                uOpStallD;
    logic                dstall;

    logic [2*NSRC-1:0]   ForwardE;
    logic                StallF;
    logic                StallD;
    logic                StallE;
    logic                StallM;
    logic                FlushD;
    logic                FlushE;
    logic                FlushW;
    logic                PCWrPendingF;
    logic [CNTW-1:0]     LdUseCount;
    logic [CNTW-1:0]     DStallCount;

    modport master (
        output RA_D, RAValidD, RA_E, RAValidE, WA_E, WA_M, WA_W,
               MemtoRegE, RegWriteM, RegWriteW, BranchTakenE, PCSrcD,
               uOpStallD, dstall,
        input  ForwardE, StallF, StallD, StallE, StallM, FlushD, FlushE,
               FlushW, PCWrPendingF, LdUseCount, DStallCount
    );

    modport slave (
        input  RA_D, RAValidD, RA_E, RAValidE, WA_E, WA_M, WA_W,
               MemtoRegE, RegWriteM, RegWriteW, BranchTakenE, PCSrcD,
               uOpStallD, dstall,
        output ForwardE, StallF, StallD, StallE, StallM, FlushD, FlushE,
               FlushW, PCWrPendingF, LdUseCount, DStallCount
    );
endinterface

// File: rtl/hazard_unit_param.sv
// Parametrised hazard and forwarding controller for the F/D/E/M/W ARM pipeline.
//   clk, reset : single clock domain, synchronous active-high reset
//   hz (slave) : register addresses and valids, control hints, and
//                forward/stall/flush outputs plus the stall-cycle counters
// hazard_src_lane performs the address compares for one source operand: the
// E-stage forward select and the D-stage load-use hit.

module hazard_src_lane #(
    parameter int RAW   = 4,
    parameter int PCREG = 15
) (
    input  logic [RAW-1:0] ra_e,
    input  logic           rv_e,
    input  logic [RAW-1:0] ra_d,
    input  logic           rv_d,
    input  logic [RAW-1:0] wa_e,
    input  logic [RAW-1:0] wa_m,
    input  logic [RAW-1:0] wa_w,
    input  logic           rw_m,
    input  logic           rw_w,
    output logic [1:0]     fwd,
    output logic           ld_hit
);
    logic not_pc_e;
    assign not_pc_e = (ra_e != RAW'(PCREG));

    // The M result is younger than the W result, so M wins.
    always_comb begin
        fwd = 2'b00;
        if (rv_e && not_pc_e && rw_m && (wa_m == ra_e))
            fwd = 2'b10;
        else if (rv_e && not_pc_e && rw_w && (wa_w == ra_e))
            fwd = 2'b01;
    end

    assign ld_hit = rv_d && (ra_d == wa_e) && (ra_d != RAW'(PCREG));
endmodule

module hazard_unit_param #(
    parameter int NSRC  = 2,
    parameter int RAW   = 4,
    parameter int PCREG = 15,
    parameter int CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_unit_param_if.slave   hz
);
    logic [NSRC-1:0][1:0] fwd;
    logic [NSRC-1:0]      ld_hit;

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        hazard_src_lane #(.RAW(RAW), .PCREG(PCREG)) u_lane (
            .ra_e   (hz.RA_E[gi*RAW +: RAW]),
            .rv_e   (hz.RAValidE[gi]),
            .ra_d   (hz.RA_D[gi*RAW +: RAW]),
            .rv_d   (hz.RAValidD[gi]),
            .wa_e   (hz.WA_E),
            .wa_m   (hz.WA_M),
            .wa_w   (hz.WA_W),
            .rw_m   (hz.RegWriteM),
            .rw_w   (hz.RegWriteW),
            .fwd    (fwd[gi]),
            .ld_hit (ld_hit[gi])
        );
    end

    assign hz.ForwardE = fwd;

    logic ld_stall;
    logic pcsrc_e, pcsrc_m, pcsrc_w;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_w, pc_pend;
    logic [CNTW-1:0] ld_cnt, ds_cnt;

    assign ld_stall = hz.MemtoRegE && (|ld_hit);

    // dstall freezes every stage and overrides LdStall and BranchTakenE.
    // The branch stays in the frozen E stage, so its flush fires after dstall drops.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        pc_pend = hz.PCSrcD | pcsrc_e | pcsrc_m;
        if (reset) begin
            // The shadow regs may still hold stale bits until the reset edge.
            pc_pend = hz.PCSrcD;
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
        end else if (hz.dstall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else begin
            stall_f = ld_stall | hz.uOpStallD | pc_pend;
            stall_d = ld_stall;
            flush_d = pc_pend | pcsrc_w | hz.BranchTakenE;
            flush_e = ld_stall | hz.BranchTakenE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcsrc_e <= 1'b0;
            pcsrc_m <= 1'b0;
            pcsrc_w <= 1'b0;
            ld_cnt  <= '0;
            ds_cnt  <= '0;
        end else begin
            pcsrc_e <= flush_e ? 1'b0 : (stall_e ? pcsrc_e : hz.PCSrcD);
            pcsrc_m <= stall_m ? pcsrc_m : pcsrc_e;
            pcsrc_w <= flush_w ? 1'b0 : pcsrc_m;
            // Both counters saturate at all-ones.
            if (ld_stall && !hz.dstall && !(&ld_cnt))
                ld_cnt <= ld_cnt + CNTW'(1);
            if (hz.dstall && !(&ds_cnt))
                ds_cnt <= ds_cnt + CNTW'(1);
        end
    end

    assign hz.StallF       = stall_f;
    assign hz.StallD       = stall_d;
    assign hz.StallE       = stall_e;
    assign hz.StallM       = stall_m;
    assign hz.FlushD       = flush_d;
    assign hz.FlushE       = flush_e;
    assign hz.FlushW       = flush_w;
    assign hz.PCWrPendingF = pc_pend;
    assign hz.LdUseCount   = ld_cnt;
    assign hz.DStallCount  = ds_cnt;
endmodule
